pkt_desc_sched: RTL and testbench

Descriptor scheduler that sequences the packet read controller. Host software writes packet descriptors (begin/end byte addresses) over an Avalon-MM CSR slave into an on-chip queue; the scheduler pops them one at a time, presents them on `pkt_begin`/`pkt_end`, pulses `rd_ctrl`, and waits for `rd_ctrl_rdy` before issuing the next. It sits between the HPS-to-FPGA lightweight bridge and the read controller.

---
 rtl/pkt_sched_pkg.sv | 11 +
 rtl/desc_fifo.sv | 41 ++++
 rtl/pkt_desc_sched.sv | 95 +++++++++
 tb/tb_pkt_desc_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_sched_pkg.sv
// pkt_sched_pkg: shared types and constants for the packet descriptor scheduler.
package pkt_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;
  localparam logic [2:0] A_CTRL = 3'd0, A_BEGIN = 3'd1, A_END = 3'd2, A_STATUS = 3'd3, A_DONE = 3'd4, A_IRQ = 3'd5;
  localparam int ST_BUSY = 16, ST_OVF = 17, ST_BAD = 18;
  localparam logic [31:0] MAX_LEN = 32'h0000_FFFF;
  typedef struct packed {
    logic [31:0] begin_addr;
    logic [31:0] end_addr;
  } desc_t;
endpackage

// File: rtl/desc_fifo.sv
// desc_fifo: synchronous descriptor FIFO with flush; head is read combinationally.
module desc_fifo
  import pkt_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  desc_t            din,
  output desc_t            dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  desc_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full    = level == LVL_W'(DEPTH);
  assign empty   = level == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push_ok && !flush) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end
endmodule

// File: rtl/pkt_desc_sched.sv
// pkt_desc_sched: CSR-fed descriptor queue that sequences the packet read controller.
// Define PKT_SCHED_IRQ_EN to build the done-pending interrupt register and irq output.
module pkt_desc_sched
  import pkt_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  csr_address,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  input  logic        csr_read,
  output logic [31:0] csr_readdata,
  output logic        rd_ctrl,
  output logic [31:0] control,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  input  logic        rd_ctrl_rdy,
  output logic        irq
);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  state_t state, nxt;
  desc_t head;
  logic [LVL_W-1:0] level;
  logic [31:0] ctrl, stage, done_cnt, status, rdata, irq_word;
  logic full, empty, busy, pop, push, flush, overflow, bad_desc, wr_end, inval, done;
  assign control = ctrl;
  assign wr_end  = csr_write && csr_address == A_END;
  assign flush   = csr_write && csr_address == A_CTRL && csr_writedata[1];
  assign inval   = csr_writedata <= stage || csr_writedata - stage > MAX_LEN;
  assign push    = wr_end && !inval && !full && !flush;
  assign pop     = state == S_IDLE && ctrl[0] && !empty;
  assign done    = state == S_WAIT && rd_ctrl_rdy;
  desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .din('{begin_addr: stage, end_addr: csr_writedata}), .dout(head),
    .level(level), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    state <= !reset ? S_IDLE : nxt;
  always_comb
    nxt = state == S_IDLE  ? (pop ? S_ISSUE : S_IDLE) :
          state == S_ISSUE ? S_WAIT :
          state == S_WAIT  ? (rd_ctrl_rdy ? S_GAP : S_WAIT) : S_IDLE;
  always_comb begin
    rd_ctrl = state == S_ISSUE;
    busy    = state != S_IDLE;
  end
  // Flush is a strobe, so bit1 never reads back as set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl      <= '0;
      stage     <= '0;
      done_cnt  <= '0;
      overflow  <= 1'b0;
      bad_desc  <= 1'b0;
      pkt_begin <= '0;
      pkt_end   <= '0;
    end else begin
      if (csr_write && csr_address == A_CTRL) ctrl <= csr_writedata & ~32'h2;
      if (csr_write && csr_address == A_BEGIN) stage <= csr_writedata;
      if (done) done_cnt <= done_cnt + 1'b1;
      if (wr_end && !inval && full && !flush) overflow <= 1'b1;
      else if (csr_write && csr_address == A_STATUS && csr_writedata[ST_OVF]) overflow <= 1'b0;
      if (wr_end && inval) bad_desc <= 1'b1;
      else if (csr_write && csr_address == A_STATUS && csr_writedata[ST_BAD]) bad_desc <= 1'b0;
      if (pop) begin
        pkt_begin <= head.begin_addr;
        pkt_end   <= head.end_addr;
      end
    end
  end
`ifdef PKT_SCHED_IRQ_EN
  logic pend;
  // A completion in the same cycle as the W1C wins so no event is lost.
  always_ff @(posedge clk)
    pend <= !reset ? 1'b0 : done ? 1'b1 : (csr_write && csr_address == A_IRQ && csr_writedata[0]) ? 1'b0 : pend;
  assign irq      = pend && ctrl[2];
  assign irq_word = {31'b0, pend};
`else
  assign irq      = 1'b0;
  assign irq_word = '0;
`endif
  assign status = {13'b0, bad_desc, overflow, busy, 16'(level)};
  always_comb
    rdata = csr_address == A_CTRL   ? ctrl :
            csr_address == A_BEGIN  ? stage :
            csr_address == A_STATUS ? status :
            csr_address == A_DONE   ? done_cnt :
            csr_address == A_IRQ    ? irq_word : '0;
  always_ff @(posedge clk)
    if (!reset) csr_readdata <= '0;
    else if (csr_read) csr_readdata <= rdata;
endmodule

// File: tb/tb_pkt_desc_sched.sv
// tb_pkt_desc_sched: directed self-checking bench for pkt_desc_sched (DEPTH=8).
module tb_pkt_desc_sched;
  logic clk = 0, reset = 0, csr_write = 0, csr_read = 0, rd_ctrl_rdy = 0;
  logic [2:0] csr_address = 0;
  logic [31:0] csr_writedata = 0;
  logic [31:0] csr_readdata, control, pkt_begin, pkt_end;
  logic rd_ctrl, irq;
  int n_chk = 0, n_bad = 0;

  pkt_desc_sched #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .csr_address(csr_address), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .rd_ctrl(rd_ctrl), .control(control), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .rd_ctrl_rdy(rd_ctrl_rdy), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1;
    tick;
    csr_write = 0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1;
    tick;
    csr_read = 0;
    d = csr_readdata;
  endtask

  task automatic push(input logic [31:0] b, input logic [31:0] e);
    csr_wr(3'd1, b);
    csr_wr(3'd2, e);
  endtask

  task automatic pulse_rdy;
    rd_ctrl_rdy = 1;
    tick;
    rd_ctrl_rdy = 0;
  endtask

  // Ticks until rd_ctrl is seen, bounded at 20.
  task automatic wait_issue(output int n);
    n = 0;
    while (!rd_ctrl && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 0;
    repeat (3) tick;
    reset = 1;
    n_chk++;
    if ({rd_ctrl, irq, csr_readdata, control, pkt_begin, pkt_end} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rd_ctrl=%b irq=%b rdata=%h ctrl=%h b=%h e=%h, want all 0",
               rd_ctrl, irq, csr_readdata, control, pkt_begin, pkt_end);
    end
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0", d); end
  endtask

  task automatic test_single;
    logic [31:0] d;
    int n, pulses;
    csr_wr(3'd0, 32'h1);
    push(32'h1000, 32'h1040);
    wait_issue(n);
    n_chk++;
    if (n !== 1) begin n_bad++; $display("FAIL single_latency: got %0d want 1", n); end
    n_chk++;
    if (pkt_begin !== 32'h1000 || pkt_end !== 32'h1040) begin
      n_bad++; $display("FAIL single_desc: got %h/%h want 1000/1040", pkt_begin, pkt_end);
    end
    pulses = 0;
    repeat (20) begin tick; pulses += int'(rd_ctrl); end
    n_chk++;
    if (pulses !== 0) begin n_bad++; $display("FAIL single_one_pulse: got %0d extra want 0", pulses); end
    pulse_rdy;
    tick;
    csr_rd(3'd4, d);
    n_chk++;
    if (d !== 32'd1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", d); end
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL single_status: got %h want 0", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [31:0] bs [3] = '{32'h100, 32'h200, 32'h300};
    logic [31:0] es [3] = '{32'h110, 32'h220, 32'h330};
    int n;
    csr_wr(3'd0, 32'h0);
    for (int i = 0; i < 3; i++) push(bs[i], es[i]);
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h3) begin n_bad++; $display("FAIL b2b_level: got %h want 3", d); end
    csr_wr(3'd0, 32'h1);
    wait_issue(n);
    n_chk++;
    if (n !== 1) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 1", n); end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (!rd_ctrl || pkt_begin !== bs[i] || pkt_end !== es[i]) begin
        n_bad++; $display("FAIL b2b_desc%0d: got rd=%b %h/%h want 1 %h/%h", i, rd_ctrl, pkt_begin, pkt_end, bs[i], es[i]);
      end
      repeat (4) tick;
      n_chk++;
      if (rd_ctrl !== 1'b0 || pkt_begin !== bs[i]) begin
        n_bad++; $display("FAIL b2b_hold%0d: got rd=%b b=%h want 0 %h", i, rd_ctrl, pkt_begin, bs[i]);
      end
      pulse_rdy;
      if (i < 2) begin
        wait_issue(n);
        n_chk++;
        if (n !== 2) begin n_bad++; $display("FAIL b2b_gap%0d: got %0d ticks want 2", i, n); end
      end
    end
    repeat (2) tick;
    csr_rd(3'd4, d);
    n_chk++;
    if (d !== 32'd4) begin n_bad++; $display("FAIL b2b_done_cnt: got %0d want 4", d); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    csr_wr(3'd0, 32'h0);
    for (int i = 0; i < 9; i++) push(32'h4000 + i * 32'h100, 32'h4040 + i * 32'h100);
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0002_0008) begin n_bad++; $display("FAIL ovf_set: got %h want 00020008", d); end
    csr_wr(3'd3, 32'h0002_0000);
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL ovf_clear: got %h want 00000008", d); end
    csr_wr(3'd0, 32'h2);
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL ovf_flush: got %h want 0", d); end
  endtask

  task automatic test_bad_desc;
    logic [31:0] d;
    push(32'h2000, 32'h2000);
    push(32'h0, 32'h1_0000);
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0004_0000) begin n_bad++; $display("FAIL bad_reject: got %h want 00040000", d); end
    push(32'h0, 32'hFFFF);
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0004_0001) begin n_bad++; $display("FAIL bad_max_len_ok: got %h want 00040001", d); end
    csr_wr(3'd3, 32'h0004_0000);
    csr_wr(3'd0, 32'h2);
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL bad_clear: got %h want 0", d); end
  endtask

  task automatic test_flush_wait;
    logic [31:0] d;
    int n, pulses;
    for (int i = 0; i < 5; i++) push(32'h8000 + i * 32'h100, 32'h8010 + i * 32'h100);
    csr_wr(3'd0, 32'h1);
    wait_issue(n);
    tick;
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0001_0004) begin n_bad++; $display("FAIL flush_pre: got %h want 00010004", d); end
    csr_wr(3'd0, 32'h3);
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0001_0000) begin n_bad++; $display("FAIL flush_level: got %h want 00010000", d); end
    n_chk++;
    if (pkt_begin !== 32'h8000) begin n_bad++; $display("FAIL flush_inflight: got %h want 8000", pkt_begin); end
    pulse_rdy;
    pulses = 0;
    repeat (10) begin tick; pulses += int'(rd_ctrl); end
    n_chk++;
    if (pulses !== 0) begin n_bad++; $display("FAIL flush_no_issue: got %0d pulses want 0", pulses); end
    pulse_rdy;
    csr_rd(3'd4, d);
    n_chk++;
    if (d !== 32'd5) begin n_bad++; $display("FAIL flush_done_cnt: got %0d want 5", d); end
    csr_rd(3'd6, d);
    n_chk++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h want 0", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    int n;
    csr_wr(3'd0, 32'h5);
    push(32'hA000, 32'hA100);
    wait_issue(n);
    tick;
    pulse_rdy;
`ifdef PKT_SCHED_IRQ_EN
    n_chk++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", irq); end
    csr_wr(3'd5, 32'h1);
    n_chk++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_w1c: got %b want 0", irq); end
    push(32'hB000, 32'hB100);
    wait_issue(n);
    tick;
    csr_address = 3'd5; csr_writedata = 32'h1; csr_write = 1; rd_ctrl_rdy = 1;
    tick;
    csr_write = 0; rd_ctrl_rdy = 0;
    n_chk++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_w1c_race: got %b want 1", irq); end
    csr_rd(3'd5, d);
    n_chk++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL irq_reg: got %h want 1", d); end
`else
    n_chk++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_tied: got %b want 0", irq); end
    csr_rd(3'd5, d);
    n_chk++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL irq_reg_absent: got %h want 0", d); end
`endif
    repeat (3) tick;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    int n;
    csr_wr(3'd0, 32'h1);
    push(32'hC000, 32'hC010);
    push(32'hD000, 32'hD010);
    wait_issue(n);
    tick;
    reset = 0;
    tick;
    reset = 1;
    n_chk++;
    if ({rd_ctrl, irq, control, pkt_begin, pkt_end} !== '0) begin
      n_bad++; $display("FAIL reset_mid_out: got rd=%b irq=%b ctrl=%h b=%h e=%h want all 0", rd_ctrl, irq, control, pkt_begin, pkt_end);
    end
    csr_rd(3'd3, d);
    n_chk++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_mid_status: got %h want 0", d); end
    csr_rd(3'd4, d);
    n_chk++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_mid_done: got %h want 0", d); end
    pulse_rdy;
    csr_rd(3'd4, d);
    n_chk++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL rdy_outside_wait: got %h want 0", d); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_bad_desc;
    test_flush_wait;
    test_irq;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
